// File: rtl/redmule_mx_decoder.sv
// MX FIFO consumer: E4M3 beats with one E8M0 block scale -> FP16 lanes, 2-stage valid/ready pipe.
// Optional sticky {nan, overflow, underflow} flags are built only with REDMULE_MX_DEC_FLAGS_EN defined.
module redmule_mx_decoder #(
    parameter int unsigned NUM_ELEMS   = 12,
    parameter int unsigned BLOCK_BEATS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    scale_valid_i,
    output logic                    scale_ready_o,
    input  logic [7:0]              scale_i,
    input  logic                    mx_valid_i,
    output logic                    mx_pop_o,
    input  logic [NUM_ELEMS*8-1:0]  mx_data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [NUM_ELEMS*16-1:0] data_o,
    output logic [2:0]              flags_o
);

    localparam int unsigned CNT_W = (BLOCK_BEATS > 1) ? $clog2(BLOCK_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_BEATS - 1);

    typedef enum logic {WAIT_SCALE = 1'b0, STREAM = 1'b1} state_e;

    function automatic logic elem_is_nan(input logic [7:0] x, input logic [7:0] s);
        return (s == 8'hFF) || (x[6:0] == 7'h7F);
    endfunction

    function automatic logic elem_is_zero(input logic [7:0] x);
        return x[6:0] == 7'h00;
    endfunction

    // Biased FP16 exponent: unbiased E4M3 exponent + (scale - 127) + 15.
    function automatic logic signed [10:0] elem_exp(input logic [7:0] x, input logic [7:0] s);
        logic signed [10:0] e;
        if (x[6:3] != 4'd0) e = signed'({7'd0, x[6:3]}) - 11'sd7;
        else if (x[2])      e = -11'sd7;
        else if (x[1])      e = -11'sd8;
        else                e = -11'sd9;
        return e + signed'({3'd0, s}) - 11'sd112;
    endfunction

    function automatic logic [2:0] elem_frac(input logic [7:0] x);
        if (x[6:3] != 4'd0) return x[2:0];
        else if (x[2])      return {x[1:0], 1'b0};
        else if (x[1])      return {x[0], 2'b00};
        else                return 3'b000;
    endfunction

    function automatic logic [15:0] conv_elem(input logic [7:0] x, input logic [7:0] s);
        logic signed [10:0] t;
        t = elem_exp(x, s);
        if (elem_is_nan(x, s))  return 16'h7E00;
        if (elem_is_zero(x))    return {x[7], 15'h0000};
        if (t > 11'sd30)        return {x[7], 15'h7C00};
        if (t < 11'sd1)         return {x[7], 15'h0000};
        return {x[7], t[4:0], elem_frac(x), 7'd0};
    endfunction

    state_e                  state_q;
    logic [CNT_W-1:0]        beat_cnt_q;
    logic [7:0]              scale_q;
    logic                    s1_valid_q, s2_valid_q;
    logic [NUM_ELEMS*8-1:0]  s1_data_q;
    logic [7:0]              s1_scale_q;
    logic [NUM_ELEMS*16-1:0] s2_data_q;
    logic [NUM_ELEMS*16-1:0] conv_data;
    logic                    s1_ready, s2_ready;

    assign s2_ready      = !s2_valid_q || ready_i;
    assign s1_ready      = !s1_valid_q || s2_ready;
    assign scale_ready_o = (state_q == WAIT_SCALE) && !clear_i;
    assign mx_pop_o      = (state_q == STREAM) && mx_valid_i && s1_ready && !clear_i;
    assign valid_o       = s2_valid_q;
    assign data_o        = s2_data_q;

    // NOTE: combinational blocks take a full default first so no path can infer a latch.
    always_comb begin
        conv_data = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            conv_data[16*i +: 16] = conv_elem(s1_data_q[8*i +: 8], s1_scale_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= WAIT_SCALE;
            beat_cnt_q <= '0;
            scale_q    <= '0;
        end else if (clear_i) begin
            state_q    <= WAIT_SCALE;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                WAIT_SCALE: begin
                    if (scale_valid_i) begin
                        scale_q    <= scale_i;
                        beat_cnt_q <= '0;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    if (mx_pop_o) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q <= '0;
                            state_q    <= WAIT_SCALE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= WAIT_SCALE;
            endcase
        end
    end

    // NOTE: datapath registers are reset as well, because data_o must read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_scale_q <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else if (clear_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            // The scale rides along with its beat so a new block never alters beats in flight.
            if (s1_ready) s1_valid_q <= mx_pop_o;
            if (mx_pop_o) begin
                s1_data_q  <= mx_data_i;
                s1_scale_q <= scale_q;
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= conv_data;
            end
        end
    end

`ifdef REDMULE_MX_DEC_FLAGS_EN
    function automatic logic [2:0] conv_flags(input logic [7:0] x, input logic [7:0] s);
        logic signed [10:0] t;
        logic               nan, live;
        t    = elem_exp(x, s);
        nan  = elem_is_nan(x, s);
        live = !nan && !elem_is_zero(x);
        return {nan, live && (t > 11'sd30), live && (t < 11'sd1)};
    endfunction

    logic [2:0] conv_ev;
    logic [2:0] s2_ev_q;
    logic [2:0] flags_q;

    always_comb begin
        conv_ev = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            conv_ev = conv_ev | conv_flags(s1_data_q[8*i +: 8], s1_scale_q);
        end
    end

    // Events accrue only when a beat actually leaves stage 2.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_ev_q <= '0;
            flags_q <= '0;
        end else if (clear_i) begin
            s2_ev_q <= '0;
            flags_q <= '0;
        end else begin
            if (s2_ready && s1_valid_q) s2_ev_q <= conv_ev;
            if (s2_valid_q && ready_i)  flags_q <= flags_q | s2_ev_q;
        end
    end

    assign flags_o = flags_q;
`else
    assign flags_o = 3'b000;
`endif

endmodule

// File: tb/tb_redmule_mx_decoder.sv
// Scoreboard bench for redmule_mx_decoder: real-valued reference model, directed blocks, random traffic.
`timescale 1ns/1ps
module tb_redmule_mx_decoder;

    localparam int NE = 12;
    localparam int BB = 4;
    localparam int W  = NE * 16;

`ifdef REDMULE_MX_DEC_FLAGS_EN
    localparam logic [2:0] FL_NAN = 3'b100, FL_OVF = 3'b010, FL_UNF = 3'b001;
`else
    localparam logic [2:0] FL_NAN = 3'b000, FL_OVF = 3'b000, FL_UNF = 3'b000;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic          scale_valid_i = 1'b0;
    logic          scale_ready_o;
    logic [7:0]    scale_i = 8'd0;
    logic          mx_valid_i = 1'b0;
    logic          mx_pop_o;
    logic [NE*8-1:0] mx_data_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [W-1:0]  data_o;
    logic [2:0]    flags_o;

    redmule_mx_decoder #(.NUM_ELEMS(NE), .BLOCK_BEATS(BB)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .scale_valid_i (scale_valid_i),
        .scale_ready_o (scale_ready_o),
        .scale_i       (scale_i),
        .mx_valid_i    (mx_valid_i),
        .mx_pop_o      (mx_pop_o),
        .mx_data_i     (mx_data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .flags_o       (flags_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   ev;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [2:0] exp_flags = 3'b000;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic void ref_elem(input logic [7:0] x, input logic [7:0] s,
                                     output logic [15:0] d, output logic [2:0] ev);
        int  ex, mant, k, frac;
        real a;
        ev   = 3'b000;
        ex   = int'(x[6:3]);
        mant = int'(x[2:0]);
        if (s == 8'hFF || (ex == 15 && mant == 7)) begin
            d  = 16'h7E00;
            ev = 3'b100;
        end else if (ex == 0 && mant == 0) begin
            d = {x[7], 15'h0000};
        end else begin
            a = (ex == 0) ? mant * pow2(-9) : (8 + mant) * pow2(ex - 10);
            a = a * pow2(int'(s) - 127);
            if (a >= pow2(16)) begin
                d  = {x[7], 15'h7C00};
                ev = 3'b010;
            end else if (a < pow2(-14)) begin
                d  = {x[7], 15'h0000};
                ev = 3'b001;
            end else begin
                k = 0;
                while (a >= 2.0) begin a = a / 2.0; k++; end
                while (a < 1.0)  begin a = a * 2.0; k--; end
                frac = int'((a - 1.0) * 1024.0);
                d = {x[7], 5'(k + 15), 10'(frac)};
            end
        end
    endfunction

    function automatic exp_t ref_beat(input logic [NE*8-1:0] beat, input logic [7:0] s);
        exp_t        e;
        logic [15:0] d;
        logic [2:0]  ev;
        e.data = '0;
        e.ev   = 3'b000;
        for (int i = 0; i < NE; i++) begin
            ref_elem(beat[8*i +: 8], s, d, ev);
            e.data[16*i +: 16] = d;
            e.ev = e.ev | ev;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic         stall_prev = 1'b0;
    logic [W-1:0] data_prev = '0;

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_ni) begin
            exp_q.delete();
            exp_flags  = 3'b000;
            stall_prev = 1'b0;
        end else begin
            check("flags", flags_o, exp_flags);
            if (stall_prev) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", data_o, data_prev);
            end
            if (clear_i) begin
                exp_q.delete();
                exp_flags  = 3'b000;
                stall_prev = 1'b0;
            end else begin
                if (valid_o && ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat: got %h expected no beat", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_o !== e.data) begin
                            failures++;
                            $display("FAIL beat_data: got %h expected %h", data_o, e.data);
                        end
`ifdef REDMULE_MX_DEC_FLAGS_EN
                        exp_flags = exp_flags | e.ev;
`endif
                    end
                end
                stall_prev = valid_o && !ready_i;
                data_prev  = data_o;
            end
        end
    end

    // ---------------- stimulus ----------------
    int              n_pops = 0;
    int              n_scales = 0;
    int              fill = -1;
    int              scale_src = -1;
    logic [NE*8-1:0] cur_beat = '0;
    logic [7:0]      model_scale = 8'd0;
    logic [7:0]      next_scale = 8'd127;

    function automatic logic [NE*8-1:0] make_beat(input int f);
        logic [NE*8-1:0] b;
        for (int i = 0; i < NE; i++) b[8*i +: 8] = (f < 0) ? 8'($urandom) : 8'(f);
        return b;
    endfunction

    function automatic logic [7:0] pick_scale(input int src);
        int r;
        if (src >= 0) return 8'(src);
        r = $urandom_range(0, 9);
        if (r == 0) return 8'hFF;
        if (r == 1) return 8'($urandom_range(0, 255));
        return 8'($urandom_range(105, 150));
    endfunction

    task automatic cycle(input logic vld, input logic rdy, input logic sv, input logic clr);
        @(posedge clk_i);
        #1;
        mx_valid_i    = vld;
        ready_i       = rdy;
        scale_valid_i = sv;
        clear_i       = clr;
        mx_data_i     = cur_beat;
        scale_i       = next_scale;
        @(negedge clk_i);
        if (mx_pop_o) begin
            check("pop_needs_valid", mx_valid_i, 1);
            check("pop_not_in_wait", scale_ready_o, 0);
        end
        if (clr) begin
            check("clear_no_pop", mx_pop_o, 0);
            check("clear_no_scale_hs", scale_valid_i & scale_ready_o, 0);
        end else begin
            if (scale_valid_i && scale_ready_o) begin
                model_scale = scale_i;
                n_scales++;
                next_scale = pick_scale(scale_src);
            end
            if (mx_pop_o) begin
                exp_q.push_back(ref_beat(cur_beat, model_scale));
                n_pops++;
                cur_beat = make_beat(fill);
            end
        end
    endtask

    task automatic setup(input int s, input int f);
        scale_src  = s;
        next_scale = pick_scale(s);
        fill       = f;
        cur_beat   = make_beat(f);
    endtask

    task automatic run_block(input int s, input int f, input logic rdy);
        int s0, p0;
        bit done;
        setup(s, f);
        s0 = n_scales;
        for (int i = 0; i < 10 && n_scales == s0; i++) cycle(1'b0, rdy, 1'b1, 1'b0);
        check("block_scale_taken", n_scales - s0, 1);
        p0   = n_pops;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cycle(1'b1, rdy, 1'b0, 1'b0);
            done = scale_ready_o;
        end
        check("block_end", done, 1);
        check("block_pops", n_pops - p0, BB);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("drain_empty", exp_q.size(), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, p0;
        bit done;
        logic [W-1:0] snap;

        // Reset state, with a non-empty FIFO at the input.
        mx_valid_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_flags", flags_o, 0);
        check("rst_pop", mx_pop_o, 0);
        check("rst_scale_ready", scale_ready_o, 1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_pop", mx_pop_o, 0);
        check("post_rst_scale_ready", scale_ready_o, 1);

        // Unity scale with latency check.
        setup(127, 8'h38);
        s0 = n_scales;
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("unity_scale_taken", n_scales - s0, 1);
        p0 = n_pops;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("unity_first_pop", mx_pop_o, 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("latency_n1_valid", valid_o, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("latency_n2_valid", valid_o, 1);
        check("latency_n2_data", data_o, {NE{16'h3C00}});
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            done = scale_ready_o;
        end
        check("unity_pops", n_pops - p0, BB);
        drain();
        check("unity_flags", flags_o, 0);

        // Scale and subnormal cases.
        run_block(128, 8'h38, 1'b1);
        run_block(127, 8'h01, 1'b1);
        run_block(127, 8'h80, 1'b1);
        drain();

        // Saturation.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_block(135, 8'h7E, 1'b1);
        drain();
        check("ovf_flags", flags_o, FL_OVF);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_block(100, 8'h38, 1'b1);
        drain();
        check("unf_flags", flags_o, FL_UNF);

        // NaN element and NaN scale.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        run_block(127, 8'h7F, 1'b1);
        run_block(255, -1, 1'b1);
        drain();
        check("nan_flags", flags_o, FL_NAN);

        // Backpressure: five stalled cycles hold exactly two beats.
        setup(127, -1);
        s0 = n_scales;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_scale_taken", n_scales - s0, 1);
        p0 = n_pops;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_valid", valid_o, 1);
        snap = data_o;
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_pops", n_pops - p0, 2);
        check("bp_stable", data_o, snap);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            done = scale_ready_o;
        end
        check("bp_block_pops", n_pops - p0, BB);
        drain();

        // Clear mid-block, then a full fresh block.
        setup(127, -1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        p0 = n_pops;
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_pre_pops", n_pops - p0, 2);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_valid", valid_o, 0);
        check("clr_scale_ready", scale_ready_o, 1);
        check("clr_no_pop_after", mx_pop_o, 0);
        run_block(127, -1, 1'b1);
        drain();

        // Asynchronous reset with beats in flight.
        setup(127, -1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", valid_o, 1);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_data", data_o, 0);
        check("arst_flags", flags_o, 0);
        check("arst_scale_ready", scale_ready_o, 1);
        check("arst_pop", mx_pop_o, 0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Random traffic.
        setup(-1, -1);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 8, $urandom_range(0, 99) == 0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/redmule_mx_decoder.md
# redmule_mx_decoder

Consumer stage directly downstream of the MX FIFO. It pops packed FP8 E4M3 element beats, applies one shared E8M0 block scale per `BLOCK_BEATS` beats, and emits FP16 lanes to the RedMulE datapath through a valid/ready handshake. The conversion is a 2-stage pipeline with full backpressure and a throughput of one beat per cycle inside a block.

## Interface
**Parameters**
- `NUM_ELEMS`, 12: elements per beat.
- `BLOCK_BEATS`, 4: beats sharing one scale. Must be ≥1.

**Ports**
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `clear_i`, in, 1: synchronous flush.
- `scale_valid_i`, in, 1: block scale available.
- `scale_ready_o`, out, 1: scale accepted.
- `scale_i`, in, 8: E8M0 scale, bias 127.
- `mx_valid_i`, in, 1: FIFO non-empty.
- `mx_pop_o`, out, 1: FIFO pop.
- `mx_data_i`, in, `NUM_ELEMS`×8: E4M3 elements.
- `valid_o`, out, 1: output beat valid.
- `ready_i`, in, 1: downstream ready.
- `data_o`, out, `NUM_ELEMS`×16: FP16 elements.
- `flags_o`, out, 3: sticky {nan, overflow, underflow}.

## Operation
- **FSM states:** WAIT_SCALE (reset state) and STREAM.
- **WAIT_SCALE:**
  - `scale_ready_o=1`, `mx_pop_o=0`.
  - On `scale_valid_i`: latch the scale, set `beat_cnt=0`, go to STREAM.
- **STREAM:**
  - `scale_ready_o=0`.
  - `mx_pop_o = mx_valid_i & s1_ready`.
  - Each pop increments `beat_cnt`. The pop with `beat_cnt==BLOCK_BEATS-1` returns the FSM to WAIT_SCALE. This costs exactly one bubble cycle per block.
- **Pipeline readies:**
  - `s2_ready = !s2_valid | ready_i`.
  - `s1_ready = !s1_valid | s2_ready`.
  - `mx_pop_o` depends combinationally on `ready_i`.
- **Stage 1:** registers the raw beat together with its scale. The scale travels with the beat, so a new scale never affects beats already in flight.
- **Stage 2:** registers the converted FP16 beat.
- **Per-element conversion:**
  - Sign is copied.
  - E4M3 normal (E≠0): unbiased exponent `e = E-7`, mantissa `1.mmm`.
  - E4M3 subnormal (E=0, m≠0): normalize.
    - m[2] set → `e=-7`, frac `{m1,m0}`.
    - m[2:1]=01 → `e=-8`, frac `{m0}`.
    - m=001 → `e=-9`, frac 0.
  - Output exponent: `t = e + (scale-127) + 15`, evaluated in signed 11-bit.
  - `t > 30` → ±inf (0x7C00|sign), sets overflow.
  - `t < 1` → ±0 (flush; FP16 subnormals are not produced), sets underflow.
  - Otherwise → `{sign, t[4:0], frac left-aligned to 10 bits}`.
  - Zero (E=0, m=0) → ±0, no flag.
  - E4M3 NaN (E=15, m=7) → 0x7E00, sets nan.
  - Scale 0xFF → every element of the beat → 0x7E00, sets nan.
- **clear_i:** has priority over all other activity.
  - Invalidates both stages.
  - FSM → WAIT_SCALE, `beat_cnt=0`.
  - Clears flags.
  - No pop or scale handshake occurs in the clear cycle.

## Timing
- **Reset values:**
  - `valid_o=0`, `data_o=0`, `flags_o=0`, `mx_pop_o=0`.
  - `scale_ready_o=1`; FSM in WAIT_SCALE, `beat_cnt=0`.
- **Latency:** a beat popped in cycle N shows `valid_o=1` in cycle N+2 if `ready_i` held high.
- **Hold rule:** `valid_o`/`data_o` hold stable while `valid_o & !ready_i`.
- **Capacity:** two beats buffered under stall. `mx_pop_o` deasserts once both stages are full and `ready_i=0`.
- **Simultaneous pop and drain:** a pop and a stage-2 drain in the same cycle are both accepted (full rate).
- **Empty FIFO:** with `mx_valid_i=0` mid-block, `beat_cnt` holds and the FSM stays in STREAM.
- **Reset mid-block:** async reset drops all state immediately. Partially consumed blocks are discarded.

## Configuration
- Macro `REDMULE_MX_DEC_FLAGS_EN`.
- **Defined:** `flags_o` holds sticky OR of the per-element events of every beat leaving stage 2 (`valid_o & ready_i`). Cleared by reset or `clear_i`.
- **Undefined:** `flags_o` is tied to 0 and no flag logic is synthesized. Conversion results are identical either way.

## Test plan
- **Unity scale:** scale 127, all elements 0x38, `ready_i=1` → `data_o` all 0x3C00 two cycles after pop. Exactly 4 pops, then `scale_ready_o=1`.
- **Scale and subnormal:** scale 128 on 0x38 → 0x4000. Scale 127 on 0x01 → 0x1800. On 0x80 → 0x8000.
- **Saturation:** scale 135 on 0x7E → 0x7C00, overflow flag set. Scale 100 on 0x38 → 0x0000, underflow set.
- **NaN:**
  - Element 0x7F → 0x7E00.
  - Scale 0xFF → every lane 0x7E00.
  - nan flag set only with the macro defined; `flags_o=0` otherwise.
- **Backpressure:** `ready_i=0` for 5 cycles with `mx_valid_i=1` → exactly 2 pops, `data_o` stable. On release, beats emerge in order without loss or duplication.
- **Clear:** `clear_i` pulsed mid-block (beat 2) → `valid_o=0` next cycle, `scale_ready_o=1`. A new scale restarts a full 4-beat block.
